// File: rtl/exec_seq_pkg.sv
// Shared encodings for the execution sequencer: FSM states, syscall codes,
// and the saturating increment used by the cycle counters.
package exec_seq_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PAUSE = 2'd1;
    localparam logic [1:0] ST_STEP  = 2'd2;
    localparam logic [1:0] ST_EXIT  = 2'd3;

    localparam logic [31:0] SYS_EXIT  = 32'h0000_000A;
    localparam logic [31:0] SYS_PRINT = 32'h0000_0022;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/go_debounce.sv
// Go button conditioning: 2-flop synchronizer, debounce counter and a
// one-cycle pulse on each accepted 0->1 transition of the stable level.
module go_debounce #(
    parameter int GO_DEBOUNCE = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic go,
    output logic go_pulse
);

    localparam int CW = (GO_DEBOUNCE < 2) ? 1 : $clog2(GO_DEBOUNCE + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          stable_reg;
    logic          pulse_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            pulse_reg  <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= go;
            sync2_reg <= sync1_reg;
            pulse_reg <= 1'b0;
            // Any sample agreeing with the stable level restarts the run count.
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(GO_DEBOUNCE - 1)) begin
                stable_reg <= sync2_reg;
                pulse_reg  <= sync2_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign go_pulse = pulse_reg;

endmodule

// File: rtl/exec_sequencer.sv
// Execution controller for the single-cycle CPU: commit enable, syscall
// pause/exit, breakpoint and single-step handling, retired/stalled counters.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int GO_DEBOUNCE = 4,
    parameter int BP_WIDTH    = 10
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                go,
    input  logic                step_mode,
    input  logic                bp_en,
    input  logic [BP_WIDTH-1:0] bp_addr,
    input  logic [31:0]         pc,
    input  logic                syscall,
    input  logic [31:0]         sys_v0,
    output logic                pc_en,
    output logic [1:0]          cpu_state,
    output logic                go_pulse,
    output logic [31:0]         retired,
    output logic [31:0]         stalled
);

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [31:0] retired_reg;
    logic [31:0] stalled_reg;
    logic        exit_hit;
    logic        pause_hit;
    logic        bp_hit;
    logic        unused_pc_bits;

    go_debounce #(
        .GO_DEBOUNCE(GO_DEBOUNCE)
    ) u_go_debounce (
        .clk      (clk),
        .clr      (clr),
        .go       (go),
        .go_pulse (go_pulse)
    );

    assign exit_hit       = syscall & (sys_v0 == SYS_EXIT);
    assign pause_hit      = syscall & (sys_v0 != SYS_PRINT) & ~exit_hit;
    assign bp_hit         = bp_en & (pc[BP_WIDTH+1:2] == bp_addr);
    assign unused_pc_bits = ^{pc[31:BP_WIDTH+2], pc[1:0]};

    always_comb begin
        state_next = state_reg;
        pc_en      = 1'b0;
        if (!clr) begin
            case (state_reg)
                ST_RUN: begin
                    if (exit_hit)                state_next = ST_EXIT;
                    else if (step_mode)          state_next = ST_STEP;
                    else if (bp_hit | pause_hit) state_next = ST_PAUSE;
                    else                         pc_en      = 1'b1;
                end
                ST_PAUSE: begin
                    // The trapped instruction retires on resume without re-checking bp/pause.
                    if (go_pulse) begin
                        if (exit_hit) begin
                            state_next = ST_EXIT;
                        end else begin
                            pc_en      = 1'b1;
                            state_next = step_mode ? ST_STEP : ST_RUN;
                        end
                    end
                end
                ST_STEP: begin
                    if (exit_hit)        state_next = ST_EXIT;
                    else if (go_pulse)   pc_en      = 1'b1;
                    else if (!step_mode) state_next = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg   <= ST_RUN;
            retired_reg <= '0;
            stalled_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (pc_en)
                retired_reg <= sat_inc(retired_reg);
            else if (state_reg != ST_EXIT)
                stalled_reg <= sat_inc(stalled_reg);
        end
    end

    assign cpu_state = state_reg;
    assign retired   = retired_reg;
    assign stalled   = stalled_reg;

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Execution controller for the single-cycle MIPS_CPU datapath.
- Generates the PC/architectural-state update enable each cycle.
- Services syscall pause/exit, PC breakpoint and single-step, using a debounced Go button.
- Counts retired and stalled cycles.
- Sits beside the PC register in the CPU top. The top gates PC load, Regwrite and Memwrite with pc_en, so a stalled cycle has no architectural side effects.

Parameters:
- GO_DEBOUNCE, 4: consecutive stable synchronized samples required before the Go level is accepted (>=1).
- BP_WIDTH, 10: number of word-address bits compared for the breakpoint (pc[BP_WIDTH+1:2]).

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous, active-high reset.
- go  in  1  raw Go button, asynchronous to clk.
- step_mode  in  1  1 = retire one instruction per accepted Go press.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  BP_WIDTH  breakpoint word address.
- pc  in  32  current PC (address of the instruction being decoded this cycle).
- syscall  in  1  current instruction is SYSCALL (from the control decoder).
- sys_v0  in  32  register $v0 value (R1_out while syscall=1).
- pc_en  out  1  commit enable for this cycle (combinational).
- cpu_state  out  2  FSM state.
- go_pulse  out  1  one-cycle accepted Go event (debug).
- retired  out  32  instructions retired.
- stalled  out  32  non-EXIT cycles with pc_en=0.

Behaviour:
- All state updates on posedge clk. clr has priority over everything.
- While clr=1, pc_en=0. At the clr edge: state=RUN, retired=0, stalled=0, synchronizer and debounce cleared, go_stable=0, go_pulse=0.
- Go path:
  - 2-flop synchronizer, then debounce counter.
  - go_stable takes the synchronized value after GO_DEBOUNCE consecutive equal samples that differ from go_stable.
  - go_pulse=1 for exactly one cycle on each 0->1 transition of go_stable.
  - go held high from edge N gives go_pulse in cycle N+2+GO_DEBOUNCE. Glitches shorter than GO_DEBOUNCE cycles give no pulse.
- Decode terms:
  - exit_hit = syscall & sys_v0==32'h0A.
  - pause_hit = syscall & sys_v0!=32'h22 & ~exit_hit. A syscall with $v0=0x22 is a display call and never stalls.
  - bp_hit = bp_en & pc[BP_WIDTH+1:2]==bp_addr.
- States: RUN=0, PAUSE=1, STEP=2, EXIT=3.
- RUN:
  - exit_hit -> pc_en=0, next EXIT.
  - else step_mode -> pc_en=0, next STEP.
  - else bp_hit | pause_hit -> pc_en=0, next PAUSE.
  - else pc_en=1, stay RUN.
  - go_pulse is ignored in RUN.
- PAUSE:
  - go_pulse=0 -> pc_en=0, stay.
  - go_pulse=1 and exit_hit -> pc_en=0, next EXIT.
  - go_pulse=1 otherwise -> pc_en=1 unconditionally (the breakpointed/paused instruction retires), next STEP if step_mode else RUN.
- STEP:
  - exit_hit -> pc_en=0, next EXIT (EXIT wins, regardless of go_pulse).
  - go_pulse=1 -> pc_en=1, stay STEP; bp_hit and pause_hit are ignored for the stepped instruction.
  - step_mode=0 and no go_pulse -> pc_en=0, next RUN.
  - otherwise pc_en=0, stay.
- EXIT: pc_en=0 permanently. Only clr leaves EXIT.
- Counters:
  - retired increments when pc_en=1.
  - stalled increments when pc_en=0, state!=EXIT and clr=0.
  - Both saturate at 32'hFFFFFFFF.
- cpu_state is registered. pc_en is combinational from state and current-cycle inputs (zero latency, as the datapath is single-cycle).

Decomposition:
- Package exec_seq_pkg: state encodings (ST_RUN, ST_PAUSE, ST_STEP, ST_EXIT), SYS_EXIT=32'h0A, SYS_PRINT=32'h22.
- Sub-module go_debounce: synchronizer, debounce counter, rising-edge pulse; parameter GO_DEBOUNCE.
- FSM and counters stay in exec_sequencer.

Test Plan:
- clr for 2 cycles, free run of 10 plain instructions with no syscall -> pc_en=1 from the first post-reset cycle, retired=10, stalled=0, cpu_state=0.
- syscall with sys_v0=0x22 for 1 cycle -> pc_en stays 1. sys_v0=0x05 -> pc_en=0, state PAUSE, stalled counts. Go held for 8 cycles (GO_DEBOUNCE=4) -> go_pulse at cycle 6, pc_en=1 in that cycle, then state RUN.
- bp_en=1, bp_addr=pc[11:2] of 0x0000_0040 -> on reaching pc=0x40: pc_en=0, PAUSE. Go press -> the instruction at 0x40 retires once, no re-trap, RUN resumes.
- step_mode=1, three Go presses with a 2-cycle glitch between them -> exactly 3 retirements, the glitch gives no go_pulse, state stays STEP. Drop step_mode -> RUN.
- syscall with sys_v0=0x0A -> pc_en=0, EXIT. Further Go presses give no retirement and stalled is frozen. Assert clr mid-EXIT -> RUN, counters 0.
